// File: rtl/ctrl_fsm_mc_if.sv
// rtl/ctrl_fsm_mc_if.sv - opcode/handshake inputs and state/retire outputs of the multicycle sequencer
// master drives the instruction/memory side; slave is the sequencer itself.
interface ctrl_fsm_mc_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                resume;
  logic [3:0]          state;
  logic                ir_we;
  logic                exe_busy;
  logic                halted;
  logic                retire;
  logic [CNT_W-1:0]    retire_cnt;

  modport master (
    output opcode, imem_ready, dmem_ready, resume,
    input  state, ir_we, exe_busy, halted, retire, retire_cnt
  );

  modport slave (
    input  opcode, imem_ready, dmem_ready, resume,
    output state, ir_we, exe_busy, halted, retire, retire_cnt
  );
endinterface

// File: rtl/ctrl_fsm_mc.sv
// rtl/ctrl_fsm_mc.sv - registered multicycle control sequencer with mem handshakes, multi-cycle multiply, halt and retire count
// The datapath control decoder consumes bus.state; retire/retire_cnt track completed instructions.
module ctrl_fsm_mc #(
  parameter int                  OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] BR_OP    = OPCODE_W'(6'b110100),
  parameter logic [OPCODE_W-1:0] LW_OP    = OPCODE_W'(6'b110001),
  parameter logic [OPCODE_W-1:0] MUL_OP   = OPCODE_W'(6'b000011),
  parameter logic [OPCODE_W-1:0] HALT_OP  = OPCODE_W'(6'b111111),
  parameter int                  MUL_LAT  = 4,
  parameter int                  CNT_W    = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  ctrl_fsm_mc_if.slave    bus
);

  localparam logic [3:0] S_IF   = 4'b0000;
  localparam logic [3:0] S_ID   = 4'b0001;
  localparam logic [3:0] S_CEXE = 4'b0010;
  localparam logic [3:0] S_MEM  = 4'b0011;
  localparam logic [3:0] S_CWB  = 4'b0100;
  localparam logic [3:0] S_BEXE = 4'b0101;
  localparam logic [3:0] S_AEXE = 4'b0110;
  localparam logic [3:0] S_AWB  = 4'b0111;
  localparam logic [3:0] S_MEXE = 4'b1000;
  localparam logic [3:0] S_HALT = 4'b1111;

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic             retire_d;
  logic             retire_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MCW-1:0]   mul_cnt;
  logic [2:0]       op_class;

  assign op_class = bus.opcode[OPCODE_W-1 -: 3];

  // mul_cnt counts remaining mEXE cycles after the current one.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IF;
      mul_cnt  <= '0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
      if (retire_d) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_ID && state_d == S_MEXE) begin
        mul_cnt <= MCW'(MUL_LAT - 1);
      end else if (state_q == S_MEXE && mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = S_IF;
    retire_d = 1'b0;
    case (state_q)
      S_IF:   state_d = bus.imem_ready ? S_ID : S_IF;
      S_ID: begin
        if (op_class == 3'b110) begin
          state_d = (bus.opcode == BR_OP) ? S_BEXE : S_CEXE;
        end else if (op_class == 3'b111) begin
          // Jumps complete in decode; the halt instruction retires on entry to HALT.
          state_d  = (bus.opcode == HALT_OP) ? S_HALT : S_IF;
          retire_d = 1'b1;
        end else if (bus.opcode == MUL_OP) begin
          state_d = S_MEXE;
        end else begin
          state_d = S_AEXE;
        end
      end
      S_AEXE: state_d = S_AWB;
      S_MEXE: state_d = (mul_cnt == '0) ? S_AWB : S_MEXE;
      S_BEXE: begin
        state_d  = S_IF;
        retire_d = 1'b1;
      end
      S_CEXE: state_d = S_MEM;
      S_MEM: begin
        if (!bus.dmem_ready) begin
          state_d = S_MEM;
        end else if (bus.opcode == LW_OP) begin
          state_d = S_CWB;
        end else begin
          state_d  = S_IF;
          retire_d = 1'b1;
        end
      end
      S_AWB, S_CWB: begin
        state_d  = S_IF;
        retire_d = 1'b1;
      end
      S_HALT: state_d = bus.resume ? S_IF : S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    bus.state      = state_q;
    bus.ir_we      = (state_q == S_IF) && bus.imem_ready;
    bus.exe_busy   = (state_q == S_MEXE);
    bus.halted     = (state_q == S_HALT);
    bus.retire     = retire_q;
    bus.retire_cnt = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// tb/tb_ctrl_fsm_mc.sv - randomized instruction-level bench for ctrl_fsm_mc, two parameter lanes
// Each lane expands instructions into expected per-cycle states from the sequencing rules.
module tb_ctrl_fsm_mc;

  localparam logic [3:0] ST_IF   = 4'b0000;
  localparam logic [3:0] ST_ID   = 4'b0001;
  localparam logic [3:0] ST_CEXE = 4'b0010;
  localparam logic [3:0] ST_MEM  = 4'b0011;
  localparam logic [3:0] ST_CWB  = 4'b0100;
  localparam logic [3:0] ST_BEXE = 4'b0101;
  localparam logic [3:0] ST_AEXE = 4'b0110;
  localparam logic [3:0] ST_AWB  = 4'b0111;
  localparam logic [3:0] ST_MEXE = 4'b1000;
  localparam logic [3:0] ST_HALT = 4'b1111;

  localparam logic [5:0] OP_BR    = 6'b110100;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_SW    = 6'b110010;
  localparam logic [5:0] OP_MUL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_JMP   = 6'b111000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef struct {
    logic [5:0] op;
    bit         im;
    bit         dm;
    bit         rs;
    bit         rst;
    logic [3:0] st;
    bit         ret;
    int         cnt;
    bit         lit_en;
    logic [3:0] lit_st;
    int         lit_cnt;
  } cyc_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit done [2];

  task automatic check(string name, int lane, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0d expected %0d at %0t", lane, name, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] r;
    case ($urandom_range(0, 7))
      0: r = OP_BR;
      1: r = OP_LW;
      2: r = OP_SW;
      3: r = OP_MUL;
      4: r = OP_HALT;
      5: r = OP_JMP;
      6: r = OP_RTYPE;
      default: r = 6'($urandom);
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int ML = (g == 0) ? 4 : 1;
    localparam int CW = (g == 0) ? 16 : 4;

    logic rst_l;
    ctrl_fsm_mc_if #(.OPCODE_W(6), .CNT_W(CW)) bus ();
    ctrl_fsm_mc #(.MUL_LAT(ML), .CNT_W(CW)) dut (.CLK(CLK), .Reset(rst_l), .bus(bus));

    cyc_t       q[$];
    int         cnt;
    bit         pend;
    bit         lit_pend;
    logic [3:0] lit_st;
    int         lit_cnt;

    // retire seen in a cycle belongs to the transition that ended the previous cycle
    task automatic push(logic [3:0] st, logic [5:0] op, bit im, bit dm, bit rs, bit leave_ret);
      cyc_t r;
      r.op = op; r.im = im; r.dm = dm; r.rs = rs; r.rst = 1'b0; r.st = st;
      r.ret = pend;
      if (pend) cnt = (cnt + 1) % (1 << CW);
      r.cnt = cnt;
      pend = leave_ret;
      r.lit_en = lit_pend; r.lit_st = lit_st; r.lit_cnt = lit_cnt;
      lit_pend = 1'b0;
      q.push_back(r);
    endtask

    task automatic push_reset();
      cyc_t r;
      r.op = OP_RTYPE; r.im = 1'b0; r.dm = rb(); r.rs = rb(); r.rst = 1'b1;
      r.st = ST_IF; r.ret = 1'b0; r.cnt = 0; r.lit_en = 1'b0; r.lit_st = ST_IF; r.lit_cnt = 0;
      cnt = 0; pend = 1'b0;
      q.push_back(r);
    endtask

    task automatic expect_next(logic [3:0] st, int c);
      lit_pend = 1'b1; lit_st = st; lit_cnt = c;
    endtask

    task automatic instr(logic [5:0] op, int ifw, int memw, int hw);
      logic [2:0] cls;
      cls = op[5:3];
      for (int i = 0; i < ifw; i++) push(ST_IF, op, 1'b0, rb(), rb(), 1'b0);
      push(ST_IF, op, 1'b1, rb(), rb(), 1'b0);
      push(ST_ID, op, rb(), rb(), rb(), cls == 3'b111);
      if (cls == 3'b110) begin
        if (op == OP_BR) begin
          push(ST_BEXE, op, rb(), rb(), rb(), 1'b1);
        end else begin
          push(ST_CEXE, op, rb(), rb(), rb(), 1'b0);
          for (int i = 0; i < memw; i++) push(ST_MEM, op, rb(), 1'b0, rb(), 1'b0);
          push(ST_MEM, op, rb(), 1'b1, rb(), op != OP_LW);
          if (op == OP_LW) push(ST_CWB, op, rb(), rb(), rb(), 1'b1);
        end
      end else if (cls == 3'b111) begin
        if (op == OP_HALT) begin
          for (int i = 0; i < hw; i++) push(ST_HALT, op, rb(), rb(), 1'b0, 1'b0);
          push(ST_HALT, op, rb(), rb(), 1'b1, 1'b0);
        end
      end else if (op == OP_MUL) begin
        for (int i = 0; i < ML; i++) push(ST_MEXE, op, rb(), rb(), rb(), 1'b0);
        push(ST_AWB, op, rb(), rb(), rb(), 1'b1);
      end else begin
        push(ST_AEXE, op, rb(), rb(), rb(), 1'b0);
        push(ST_AWB, op, rb(), rb(), rb(), 1'b1);
      end
    endtask

    task automatic build();
      cnt = 0; pend = 1'b0; lit_pend = 1'b0; lit_st = ST_IF; lit_cnt = 0;
      push_reset();
      if (g == 0) begin
        instr(OP_RTYPE, 0, 0, 0);
        expect_next(ST_IF, 1);
        instr(OP_LW, 1, 3, 0);
        instr(OP_SW, 0, 2, 0);
        instr(OP_MUL, 0, 0, 0);
        instr(OP_HALT, 0, 0, 10);
        instr(OP_JMP, 2, 0, 0);
        expect_next(ST_IF, 6);
        push(ST_IF, OP_MUL, 1'b1, rb(), rb(), 1'b0);
        push(ST_ID, OP_MUL, rb(), rb(), rb(), 1'b0);
        push(ST_MEXE, OP_MUL, rb(), rb(), rb(), 1'b0);
        push_reset();
        instr(OP_RTYPE, 0, 0, 0);
        expect_next(ST_IF, 1);
        for (int i = 0; i < 150; i++)
          instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < 16; i++) instr(OP_BR, 0, 0, 0);
        expect_next(ST_IF, 0);
        instr(OP_MUL, 0, 0, 0);
        expect_next(ST_IF, 1);
        for (int i = 0; i < 100; i++)
          instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    endtask

    initial begin
      cyc_t r;
      rst_l = 1'b1;
      bus.opcode = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.resume = 1'b0;
      build();
      while (q.size() > 0) begin
        r = q.pop_front();
        @(negedge CLK);
        bus.opcode = r.op; bus.imem_ready = r.im; bus.dmem_ready = r.dm; bus.resume = r.rs;
        if (r.rst) rst_l = 1'b1;
        #1;
        check("state", g, 32'(bus.state), 32'(r.st));
        check("retire", g, 32'(bus.retire), 32'(r.ret));
        check("retire_cnt", g, 32'(bus.retire_cnt), r.cnt);
        check("ir_we", g, 32'(bus.ir_we), 32'((r.st == ST_IF) && r.im));
        check("exe_busy", g, 32'(bus.exe_busy), 32'(r.st == ST_MEXE));
        check("halted", g, 32'(bus.halted), 32'(r.st == ST_HALT));
        if (r.lit_en) begin
          check("lit_state", g, 32'(bus.state), 32'(r.lit_st));
          check("lit_retire", g, 32'(bus.retire), 32'd1);
          check("lit_cnt", g, 32'(bus.retire_cnt), r.lit_cnt);
        end
        rst_l = 1'b0;
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    int cycles;
    cycles = 0;
    while (!(done[0] && done[1]) && cycles < 60000) begin
      @(posedge CLK);
      cycles++;
    end
    if (!(done[0] && done[1])) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: lanes done %0d%0d expected 11", done[0], done[1]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
